// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-and-add multiplier beside the EX-stage ALU.
// Runs one N-bit add per cycle over N cycles and then fixes the sign, so one
// multiply takes N+3 cycles from start to the next possible start.
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   start_i, signed_i     request + operand signedness (sampled when ready_o)
//   a_i, b_i              multiplicand / multiplier (sampled with start_i)
//   flush_i               abort the operation in flight (RUN/FIX)
//   ready_o, busy_o       idle / operation in flight
//   done_o, prod_o        one-cycle completion pulse, registered 2N-bit product
module alu_mul_seq #(
  parameter int N = 64
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           start_i,
  input  logic           signed_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  input  logic           flush_i,
  output logic           ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] prod_o
);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    mcand, mlier, acc_hi;
  logic            neg;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic [N-1:0]    a_mag, b_mag;
  logic [N:0]      sum_w;
  logic [2*N-1:0]  raw, fixed;

  assign accept = (state == IDLE) && start_i && !flush_i;

  // Unsigned magnitudes; -2^(N-1) negates to itself, which reads correctly
  // as 2^(N-1) unsigned.
  assign a_mag = (signed_i && a_i[N-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[N-1]) ? -b_i : b_i;

  // One adder step; the carry is kept as the top bit and shifted into acc_hi.
  assign sum_w = {1'b0, acc_hi} + {1'b0, (mlier[0] ? mcand : '0)};

  assign raw   = {acc_hi, mlier};
  assign fixed = neg ? -raw : raw;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (flush_i)             state_nxt = IDLE;
        else if (cnt == CW'(1))  state_nxt = FIX;   // counter hits 0 this cycle
      end
      FIX:  state_nxt = flush_i ? IDLE : DONE;
      DONE: state_nxt = IDLE;                        // flush/start ignored here
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand  <= '0;
      mlier  <= '0;
      acc_hi <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      prod_o <= '0;
    end else begin
      if (accept) begin
        mcand  <= a_mag;
        mlier  <= b_mag;
        acc_hi <= '0;
        neg    <= signed_i & (a_i[N-1] ^ b_i[N-1]);
        cnt    <= CW'(N);
      end else if (state == RUN) begin
        {acc_hi, mlier} <= {sum_w, mlier[N-1:1]};
        cnt             <= cnt - CW'(1);
      end
      // A flushed FIX leaves the previous result visible.
      if (state == FIX && !flush_i) prod_o <= fixed;
    end
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = (state == RUN) || (state == FIX);
  assign done_o  = (state == DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of alu_mul_seq at N=8 and N=64.
// Two instances share clock/reset; 'wide' selects which one a run talks to.
module tb_alu_mul_seq;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, sgn, flush, wide;
  logic [63:0]  a, b;

  logic         rdy8, bsy8, dn8, rdy64, bsy64, dn64;
  logic [15:0]  prod8;
  logic [127:0] prod64;

  logic         rdy, bsy, dn;
  logic [127:0] prod;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.N(8)) u_d8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start & ~wide), .signed_i(sgn),
    .a_i(a[7:0]), .b_i(b[7:0]), .flush_i(flush),
    .ready_o(rdy8), .busy_o(bsy8), .done_o(dn8), .prod_o(prod8)
  );

  alu_mul_seq #(.N(64)) u_d64 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start & wide), .signed_i(sgn),
    .a_i(a), .b_i(b), .flush_i(flush),
    .ready_o(rdy64), .busy_o(bsy64), .done_o(dn64), .prod_o(prod64)
  );

  assign rdy  = wide ? rdy64 : rdy8;
  assign bsy  = wide ? bsy64 : bsy8;
  assign dn   = wide ? dn64  : dn8;
  assign prod = wide ? prod64 : {112'b0, prod8};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle (cycle 0). Returns in cycle N+3 (IDLE again).
  task automatic run(input logic s, input logic [63:0] av, input logic [63:0] bv,
                     input logic [127:0] ep, input string tag);
    int n;
    n = wide ? 64 : 8;
    start = 1'b1; sgn = s; a = av; b = bv;
    chkb({tag, ":ready0"}, rdy, 1'b1);
    step();
    // Scramble operands after the start cycle; they must not be re-sampled.
    start = 1'b0; sgn = ~s; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    for (int c = 1; c <= n + 3; c++) begin
      chkb({tag, ":busy"},  bsy, c <= n + 1);
      chkb({tag, ":done"},  dn,  c == n + 2);
      chkb({tag, ":ready"}, rdy, c == n + 3);
      if (c == n + 2) chk({tag, ":prod"}, prod, ep);
      if (c < n + 3) step();
    end
  endtask

  // Back-to-back vectors: signedness, a, b, expected product
  logic        bb_s [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0]  bb_a [3] = '{8'h12, 8'h81, 8'h10};
  logic [7:0]  bb_b [3] = '{8'h34, 8'h02, 8'h10};
  logic [15:0] bb_p [3] = '{16'h03A8, 16'hFF02, 16'h0100};

  initial begin
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; flush = 1'b0; wide = 1'b0;
    a = '0; b = '0;
    #2;
    chkb("rst:ready", rdy, 1'b1);
    chkb("rst:busy",  bsy, 1'b0);
    chkb("rst:done",  dn,  1'b0);
    chk ("rst:prod",  prod, 128'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // N=8 directed products
    run(1'b0, 64'hFF, 64'hFF, 128'hFE01, "u_ff_ff");
    run(1'b1, 64'hFD, 64'h05, 128'hFFF1, "s_m3_5");
    run(1'b0, 64'hFD, 64'h05, 128'h04F1, "u_fd_5");
    run(1'b1, 64'h80, 64'h80, 128'h4000, "s_min_min");
    run(1'b1, 64'h80, 64'h01, 128'hFF80, "s_min_1");
    run(1'b1, 64'h7F, 64'h7F, 128'h3F01, "s_max_max");
    run(1'b1, 64'hFF, 64'hFF, 128'h0001, "s_m1_m1");
    run(1'b0, 64'h00, 64'hAB, 128'h0000, "u_0_ab");
    run(1'b0, 64'h03, 64'h04, 128'h000C, "u_3_4");

    // Flush in cycle 4 of 7x9; start (and flush) held through cycle 9
    start = 1'b1; sgn = 1'b0; a = 64'd7; b = 64'd9;
    step();
    for (int c = 1; c <= 12; c++) begin
      if (c == 4)  flush = 1'b1;
      if (c == 10) begin start = 1'b0; flush = 1'b0; end
      chkb("fl:done",  dn,  1'b0);
      chkb("fl:busy",  bsy, c <= 4);
      chkb("fl:ready", rdy, c >= 5);
      chk ("fl:prod",  prod, 128'h000C);
      step();
    end

    // Back-to-back with start held high; only every 11th cycle may accept
    start = 1'b1;
    for (int c = 0; c < 33; c++) begin
      int k, p;
      k = c / 11; p = c % 11;
      if (p == 0) begin
        sgn = bb_s[k]; a = {56'b0, bb_a[k]}; b = {56'b0, bb_b[k]};
      end else begin
        sgn = $urandom_range(0, 1) != 0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      end
      chkb("bb:ready", rdy, p == 0);
      chkb("bb:busy",  bsy, p >= 1 && p <= 9);
      chkb("bb:done",  dn,  p == 10);
      if (p == 10) chk("bb:prod", prod, {112'b0, bb_p[k]});
      step();
    end
    start = 1'b0;
    chkb("bb:ready_end", rdy, 1'b1);

    // N=64: full-width unsigned, then asynchronous reset mid-run
    wide = 1'b1;
    run(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "w_max_max");
    start = 1'b1; sgn = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd2;
    step();
    start = 1'b0;
    repeat (29) step();                 // now in cycle 30
    chkb("wr:busy_pre", bsy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk ("wr:prod",  prod, 128'h0);
    chkb("wr:ready", rdy, 1'b1);
    chkb("wr:done",  dn,  1'b0);
    chkb("wr:busy",  bsy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    run(1'b0, 64'd1, 64'd1, 128'h1, "w_1_1");
    run(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        128'h4000_0000_0000_0000_0000_0000_0000_0000, "w_smin_smin");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
